// File: rtl/proyecto_pkg.sv
// Shared encodings and widths for the channel sequencer and its index counter.
package proyecto_pkg;

  localparam int NUM_CANALES_MAX = 16;
  localparam int SEL_W           = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_FULL = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    LOAD = ST_LOAD,
    FULL = ST_FULL
  } estado_t;

endpackage

// File: rtl/contador_indice.sv
// Modulo-MODULO up-counter with synchronous clear and terminal-count flag.
// Wraps to 0 on the increment taken at MODULO-1.
module contador_indice
  import proyecto_pkg::*;
#(
  parameter int MODULO = NUM_CANALES_MAX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [SEL_W-1:0] cuenta_o,
  output logic             tc_o
);

  logic [SEL_W-1:0] cuenta_q, cuenta_d;

  assign tc_o     = (cuenta_q == SEL_W'(MODULO - 1));
  assign cuenta_o = cuenta_q;

  always_comb begin
    cuenta_d = cuenta_q;
    if (clr_i) begin
      cuenta_d = '0;
    end else if (inc_i) begin
      cuenta_d = tc_o ? '0 : cuenta_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cuenta_q <= '0;
    end else begin
      cuenta_q <= cuenta_d;
    end
  end

endmodule

// File: rtl/secuenciador_canales.sv
// Assigns each accepted pixel a channel index, emits a registered write strobe one
// cycle after accept, and holds in FULL with block_full until the filter core acks.
module secuenciador_canales
  import proyecto_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int NUM_CANALES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [SEL_W-1:0]  sel,
  output logic              wr_en,
  output logic [DATA_W-1:0] data_out,
  output logic              block_full,
  input  logic              filt_ack,
  output logic [15:0]       block_cnt
);

  estado_t           state_q, state_d;
  logic [SEL_W-1:0]  indice;
  logic              indice_tc;
  logic              accept;
  logic              ack_ok;
  logic              idx_clr;
  logic              wr_en_q;
  logic [SEL_W-1:0]  sel_q;
  logic [DATA_W-1:0] data_q;
  logic              block_full_q;
  logic [15:0]       block_cnt_q;

  // clear beats both a same-cycle accept and a same-cycle ack
  assign in_ready = (state_q == LOAD);
  assign accept   = in_ready && in_valid && !clear;
  assign ack_ok   = (state_q == FULL) && filt_ack && !clear;
  assign idx_clr  = (state_q == IDLE) || clear;

  contador_indice #(
    .MODULO (NUM_CANALES)
  ) u_indice (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (idx_clr),
    .inc_i    (accept),
    .cuenta_o (indice),
    .tc_o     (indice_tc)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (enable) state_d = LOAD;
      LOAD: begin
        if (clear) begin
          state_d = IDLE;
        end else if (accept && indice_tc) begin
          state_d = FULL;
        end
      end
      FULL: begin
        if (clear) begin
          state_d = IDLE;
        end else if (ack_ok) begin
          state_d = enable ? LOAD : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wr_en_q      <= 1'b0;
      sel_q        <= '0;
      data_q       <= '0;
      block_full_q <= 1'b0;
      block_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      wr_en_q      <= accept;
      block_full_q <= (state_d == FULL);
      if (accept) begin
        sel_q  <= indice;
        data_q <= in_data;
      end
      if (ack_ok) begin
        block_cnt_q <= block_cnt_q + 16'd1;
      end
    end
  end

  assign wr_en      = wr_en_q;
  assign sel        = sel_q;
  assign data_out   = data_q;
  assign block_full = block_full_q;
  assign block_cnt  = block_cnt_q;

endmodule

// File: tb/tb_secuenciador_canales.sv
// Drives a 16-channel and a 9-channel sequencer from shared stimulus; a per-instance
// reference model queues expected writes and a negedge monitor compares.
module tb_secuenciador_canales;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic       filt_ack = 1'b0;
  logic [7:0] in_data = 8'h00;

  logic        rdy [2];
  logic [3:0]  sel [2];
  logic        wr  [2];
  logic [7:0]  dat [2];
  logic        bf  [2];
  logic [15:0] cnt [2];

  always #5 clk = ~clk;

  secuenciador_canales #(.DATA_W(8), .NUM_CANALES(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
    .in_valid(in_valid), .in_data(in_data), .in_ready(rdy[0]), .sel(sel[0]),
    .wr_en(wr[0]), .data_out(dat[0]), .block_full(bf[0]), .filt_ack(filt_ack),
    .block_cnt(cnt[0])
  );

  secuenciador_canales #(.DATA_W(8), .NUM_CANALES(9)) u_dut9 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
    .in_valid(in_valid), .in_data(in_data), .in_ready(rdy[1]), .sel(sel[1]),
    .wr_en(wr[1]), .data_out(dat[1]), .block_full(bf[1]), .filt_ack(filt_ack),
    .block_cnt(cnt[1])
  );

  int checks = 0;
  int failures = 0;

  // Model: phase 0 = idle, 1 = loading, 2 = waiting for ack
  int         m_n      [2] = '{16, 9};
  int         m_phase  [2];
  int         m_pos    [2];
  int         m_blocks [2];
  int         m_acc    [2];
  logic [3:0] last_sel [2];
  logic [7:0] last_dat [2];
  logic [11:0] q0[$];
  logic [11:0] q1[$];

  task automatic chk(int k, string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[inst%0d] t=%0t actual=%0d required=%0d", name, k, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_phase[k]  = 0;
      m_pos[k]    = 0;
      m_blocks[k] = 0;
      last_sel[k] = '0;
      last_dat[k] = '0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic model_step(int k);
    logic [3:0] p;
    case (m_phase[k])
      0: if (enable) begin m_phase[k] = 1; m_pos[k] = 0; end
      1: begin
        if (clear) begin
          m_phase[k] = 0;
          m_pos[k]   = 0;
        end else if (in_valid) begin
          p = m_pos[k][3:0];
          if (k == 0) q0.push_back({p, in_data});
          else        q1.push_back({p, in_data});
          m_acc[k]++;
          m_pos[k]++;
          if (m_pos[k] == m_n[k]) begin
            m_phase[k] = 2;
            m_pos[k]   = 0;
          end
        end
      end
      default: begin
        if (clear) begin
          m_phase[k] = 0;
          m_pos[k]   = 0;
        end else if (filt_ack) begin
          m_blocks[k] = (m_blocks[k] + 1) % 65536;
          m_phase[k]  = enable ? 1 : 0;
        end
      end
    endcase
  endtask

  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else for (int k = 0; k < 2; k++) model_step(k);
  end

  task automatic mon(int k);
    int pending;
    logic [11:0] v;
    chk(k, "in_ready", int'(rdy[k]), int'(m_phase[k] == 1));
    chk(k, "block_full", int'(bf[k]), int'(m_phase[k] == 2));
    chk(k, "block_cnt", int'(cnt[k]), m_blocks[k]);
    pending = (k == 0) ? q0.size() : q1.size();
    chk(k, "wr_en", int'(wr[k]), int'(pending != 0));
    if (pending != 0) begin
      v = (k == 0) ? q0.pop_front() : q1.pop_front();
      chk(k, "sel", int'(sel[k]), int'(v[11:8]));
      chk(k, "data_out", int'(dat[k]), int'(v[7:0]));
      last_sel[k] = v[11:8];
      last_dat[k] = v[7:0];
    end else begin
      chk(k, "sel_hold", int'(sel[k]), int'(last_sel[k]));
      chk(k, "data_hold", int'(dat[k]), int'(last_dat[k]));
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic timeout(string name);
    checks++;
    failures++;
    $display("FAIL %s timeout t=%0t actual=expired required=event", name, $time);
  endtask

  task automatic load_block(logic [7:0] base);
    int start = m_acc[0];
    int guard = 0;
    while ((m_acc[0] - start) < 16 && guard < 200) begin
      in_valid = 1'b1;
      in_data  = base + 8'(m_acc[0] - start);
      step();
      guard++;
    end
    in_valid = 1'b0;
    if (guard >= 200) timeout("load_block");
  endtask

  task automatic pulse_ack();
    filt_ack = 1'b1;
    step();
    filt_ack = 1'b0;
  endtask

  initial begin
    int guard;
    model_reset();
    m_acc[0] = 0;
    m_acc[1] = 0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Back-to-back block, then stall in FULL with input still offered
    enable = 1'b1;
    load_block(8'h10);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    repeat (5) step();
    in_valid = 1'b0;
    pulse_ack();
    load_block(8'h20);
    pulse_ack();

    // Throttled input
    for (int i = 0; i < 40; i++) begin
      in_valid = i[0];
      in_data  = 8'($urandom);
      step();
    end
    in_valid = 1'b0;
    pulse_ack();
    step();

    // clear coincident with the accept at index 6
    guard = 0;
    while (!(m_phase[0] == 1 && m_pos[0] == 6) && guard < 100) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      filt_ack = (m_phase[0] == 2);
      step();
      guard++;
    end
    filt_ack = 1'b0;
    if (guard >= 100) timeout("reach_index6");
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h77;
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    step();
    load_block(8'h40);
    pulse_ack();

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      enable   = ($urandom_range(0, 7) != 0);
      in_valid = 1'($urandom);
      in_data  = 8'($urandom);
      filt_ack = ($urandom_range(0, 3) == 0);
      clear    = ($urandom_range(0, 49) == 0);
      step();
    end
    clear  = 1'b0;
    enable = 1'b1;

    // Asynchronous reset while index 11 is being written
    guard = 0;
    while (!(m_phase[0] == 1 && m_pos[0] == 12) && guard < 200) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      filt_ack = (m_phase[0] == 2);
      step();
      guard++;
    end
    filt_ack = 1'b0;
    in_valid = 1'b0;
    if (guard >= 200) timeout("reach_index11");
    chk(0, "wr_en_before_reset", int'(wr[0]), 1);
    rst_n = 1'b0;
    #1;
    model_reset();
    mon(0);
    mon(1);
    step();
    rst_n = 1'b1;
    load_block(8'h60);
    step();

    chk(0, "queue_drained", q0.size(), 0);
    chk(1, "queue_drained", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
